br_write_arbiter: RTL
=====================

// Module: br_write_arbiter
// PURPOSE
//  Shares the register bank's single write port (we/a3/wd3) between two producers:
//   - in-order writeback (WB), which has fixed priority and no backpressure;
//   - a long-latency unit (LU: load/mul/div), which uses a valid/ready handshake.
//  Buffers LU results in a small FIFO and keeps a busy scoreboard of LU destinations.
//  Raises stall for the issue stage on RAW/WAW hazards against pending LU writes.
//  Sits between the pipeline's writeback stage, the LU and the register bank.
// PARAMETERS
//  DEPTH         2   LU result FIFO entries (power of 2, >=2)
//  STARVE_LIMIT  4   consecutive cycles a non-empty FIFO is blocked by WB before force_bubble asserts
// PORTS
//  clk          in   1   clock, all state updates on posedge
//  rst          in   1   asynchronous, active-high reset
//  wb_we        in   1   WB write request (always granted)
//  wb_addr      in   5   WB destination register
//  wb_data      in   32  WB data
//  lu_valid     in   1   LU result valid
//  lu_ready     out  1   FIFO can accept an LU result
//  lu_addr      in   5   LU destination register
//  lu_data      in   32  LU result data
//  iss_valid    in   1   issue of an LU op this cycle (marks iss_rd busy)
//  iss_rd       in   5   destination of the issued LU op
//  chk_a1       in   5   source 1 of the instruction in issue
//  chk_a2       in   5   source 2 of the instruction in issue
//  chk_rd       in   5   destination of the instruction in issue
//  stall        out  1   busy[chk_a1] | busy[chk_a2] | busy[chk_rd] (combinational)
//  force_bubble out  1   pipeline must not assert wb_we next cycle
//  br_we        out  1   to register bank we
//  br_a3        out  5   to register bank a3
//  br_wd3       out  32  to register bank wd3
//  fifo_count   out  $clog2(DEPTH)+1  current FIFO occupancy
// BEHAVIOUR
//  Reset (async): FIFO empty, busy[31:0] = 0, starve counter = 0, force_bubble = 0; lu_ready = 0 while rst is high.
//  Write port (combinational, same cycle):
//   - wb_we = 1: br_we = 1, br_a3 = wb_addr, br_wd3 = wb_data.
//   - otherwise, FIFO non-empty: drive the head entry and pop on this edge.
//   - otherwise br_we = 0; br_a3 and br_wd3 = 0.
//   - Any selected address of 0 forces br_we = 0; that FIFO entry is still popped.
//  LU accept: push on posedge when lu_valid & lu_ready.
//   - lu_ready = (fifo_count < DEPTH), or (FIFO full and a pop occurs this cycle).
//   - No bypass: minimum LU-to-bank latency is 1 cycle after accept.
//  FIFO: circular buffer with wrap-around pointers; push and pop in the same cycle leave the count unchanged.
//  Scoreboard:
//   - set busy[iss_rd] on iss_valid when iss_rd != 0;
//   - clear busy[a3] when a FIFO entry commits to the bank;
//   - set and clear of the same register in the same cycle: set wins.
//   - busy[0] is always 0.
//  Starvation:
//   - counter increments each cycle the FIFO is non-empty and wb_we = 1; otherwise it resets to 0.
//   - at STARVE_LIMIT, force_bubble is registered high for exactly 1 cycle and the counter resets.
//   - if wb_we is asserted during a bubble anyway, WB still wins and sim flags an assertion error.
//  Upstream never issues an LU op whose rd is busy (stall covers WAW); the FIFO therefore never holds two entries for one register.
// STRUCTURE
//  Package br_pkg: XLEN=32, REG_ADDR_W=5, NREGS=32, typedef struct {addr,data} wr_req_t.
//  One sub-module, br_wr_fifo (param DEPTH, wr_req_t payload, push/pop/full/empty/count).
//  Arbitration, scoreboard and starve counter live in the top level.
// TESTING
//  1 WB only: wb_we=1, addr=5, data=0xDEADBEEF -> br_we=1, a3=5, wd3=0xDEADBEEF in the same cycle.
//  2 Collision: iss x7, LU result (7, 0x11) while wb_we=1 every cycle -> LU held, force_bubble after 4 cycles, x7 written in the bubble, busy[7] clears.
//  3 Full: DEPTH=2, two LU results with wb_we=1 -> lu_ready=0; release WB -> pops in order, lu_ready=1 after the first pop.
//  4 Hazard: iss x9, then chk_a2=9 -> stall=1 until the LU write to x9 commits; stall=0 the next cycle.
//  5 x0: iss_rd=0 leaves busy unchanged; LU/WB write to addr 0 gives br_we=0, FIFO still pops.
//  6 Reset mid-operation: FIFO at 2 and busy[3] set, rst=1 -> count=0, busy=0, br_we=0 immediately.

Source files
------------

// File: rtl/br_pkg.sv
// rtl/br_pkg.sv - shared types and widths for the register-bank write arbiter
// Purpose: register file geometry and the write-request payload carried
//          through the LU result FIFO.
// Contents: XLEN, REG_ADDR_W, NREGS, wr_req_t {addr, data}.
package br_pkg;

  localparam int XLEN       = 32;
  localparam int REG_ADDR_W = 5;
  localparam int NREGS      = 32;

  typedef struct packed {
    logic [REG_ADDR_W-1:0] addr;
    logic [XLEN-1:0]       data;
  } wr_req_t;

endpackage

// File: rtl/br_write_arbiter_if.sv
// rtl/br_write_arbiter_if.sv - pipeline/LU/bank signal bundle for the write arbiter
// Purpose: groups every non-clock signal of br_write_arbiter.
// Modports: slave  - seen by the arbiter (WB, LU, issue and check inputs;
//                    lu_ready, stall, force_bubble, bank write port, fifo_count out)
//           master - seen by the surrounding pipeline/bench (mirror image).
interface br_write_arbiter_if import br_pkg::*; #(
  parameter int DEPTH = 2
) ();

  logic                  wb_we;
  logic [REG_ADDR_W-1:0] wb_addr;
  logic [XLEN-1:0]       wb_data;

  logic                  lu_valid;
  logic                  lu_ready;
  logic [REG_ADDR_W-1:0] lu_addr;
  logic [XLEN-1:0]       lu_data;

  logic                  iss_valid;
  logic [REG_ADDR_W-1:0] iss_rd;
  logic [REG_ADDR_W-1:0] chk_a1;
  logic [REG_ADDR_W-1:0] chk_a2;
  logic [REG_ADDR_W-1:0] chk_rd;
  logic                  stall;
  logic                  force_bubble;

  logic                  br_we;
  logic [REG_ADDR_W-1:0] br_a3;
  logic [XLEN-1:0]       br_wd3;

  logic [$clog2(DEPTH):0] fifo_count;

  modport slave (
    input  wb_we, wb_addr, wb_data,
    input  lu_valid, lu_addr, lu_data,
    output lu_ready,
    input  iss_valid, iss_rd, chk_a1, chk_a2, chk_rd,
    output stall, force_bubble,
    output br_we, br_a3, br_wd3,
    output fifo_count
  );

  modport master (
    output wb_we, wb_addr, wb_data,
    output lu_valid, lu_addr, lu_data,
    input  lu_ready,
    output iss_valid, iss_rd, chk_a1, chk_a2, chk_rd,
    input  stall, force_bubble,
    input  br_we, br_a3, br_wd3,
    input  fifo_count
  );

endinterface

// File: rtl/br_wr_fifo.sv
// rtl/br_wr_fifo.sv - circular buffer holding LU results awaiting the bank write port
// Purpose: DEPTH-entry FIFO of wr_req_t with wrap-around pointers.
// Ports: clk, rst (async, active high), push/push_data, pop, head (current
//        oldest entry), full, empty, count (occupancy, $clog2(DEPTH)+1 bits).
module br_wr_fifo import br_pkg::*; #(
  parameter int DEPTH = 2
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   push,
  input  wr_req_t                push_data,
  input  logic                   pop,
  output wr_req_t                head,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  wr_req_t       mem [DEPTH];
  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic          do_push;
  logic          do_pop;

  // A push into a full buffer is only legal when the head leaves on the same edge.
  assign do_pop  = pop && !empty;
  assign do_push = push && (!full || do_pop);

  assign full  = (count == CW'(DEPTH));
  assign empty = (count == '0);
  assign head  = mem[rd_ptr];

  always_ff @(posedge clk) begin
    if (do_push) mem[wr_ptr] <= push_data;
  end

  // DEPTH is a power of two, so pointers wrap by natural overflow.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + PW'(1);
      if (do_pop)  rd_ptr <= rd_ptr + PW'(1);
      case ({do_push, do_pop})
        2'b10:   count <= count + CW'(1);
        2'b01:   count <= count - CW'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/br_write_arbiter.sv
// rtl/br_write_arbiter.sv - shares the register bank write port between WB and the LU
// Purpose: WB has fixed priority; LU results queue in br_wr_fifo and drain
//          whenever WB is idle. A busy scoreboard of pending LU destinations
//          drives stall, and a starve counter requests a WB bubble when the
//          queue has been blocked too long.
// Ports: clk, rst (async, active high), bus (br_write_arbiter_if.slave):
//        wb_we/wb_addr/wb_data in, lu_valid/lu_addr/lu_data in, lu_ready out,
//        iss_valid/iss_rd and chk_a1/chk_a2/chk_rd in, stall/force_bubble out,
//        br_we/br_a3/br_wd3 out to the bank, fifo_count out.
module br_write_arbiter import br_pkg::*; #(
  parameter int DEPTH        = 2,
  parameter int STARVE_LIMIT = 4
) (
  input logic                 clk,
  input logic                 rst,
  br_write_arbiter_if.slave   bus
);

  localparam int CW = $clog2(DEPTH) + 1;
  localparam int SW = $clog2(STARVE_LIMIT + 1);

  wr_req_t          head;
  wr_req_t          lu_req;
  wr_req_t          sel;
  logic             full;
  logic             empty;
  logic             pop;
  logic             push;
  logic [CW-1:0]    count;

  logic [NREGS-1:0] busy;
  logic [NREGS-1:0] busy_next;
  logic [SW-1:0]    starve_cnt;
  logic             force_bubble_q;

  // The FIFO head only reaches the bank in cycles WB leaves the port free.
  assign pop    = !bus.wb_we && !empty;
  assign bus.lu_ready = !rst && (!full || pop);
  assign push   = bus.lu_valid && bus.lu_ready;
  assign lu_req = '{addr: bus.lu_addr, data: bus.lu_data};

  br_wr_fifo #(.DEPTH(DEPTH)) u_fifo (
    .clk       (clk),
    .rst       (rst),
    .push      (push),
    .push_data (lu_req),
    .pop       (pop),
    .head      (head),
    .full      (full),
    .empty     (empty),
    .count     (count)
  );

  assign bus.fifo_count = count;

  always_comb begin
    sel = '0;
    if (bus.wb_we)   sel = '{addr: bus.wb_addr, data: bus.wb_data};
    else if (!empty) sel = head;
  end

  // x0 is never written, but a popped x0 entry is still consumed.
  assign bus.br_we  = (bus.wb_we || !empty) && (sel.addr != '0);
  assign bus.br_a3  = sel.addr;
  assign bus.br_wd3 = sel.data;

  // Clear before set so a new issue to a register that commits this cycle stays busy.
  always_comb begin
    busy_next = busy;
    if (pop) busy_next[head.addr] = 1'b0;
    if (bus.iss_valid && (bus.iss_rd != '0)) busy_next[bus.iss_rd] = 1'b1;
    busy_next[0] = 1'b0;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) busy <= '0;
    else     busy <= busy_next;
  end

  assign bus.stall = busy[bus.chk_a1] | busy[bus.chk_a2] | busy[bus.chk_rd];

  // The bubble pulse is raised on the edge that completes STARVE_LIMIT blocked cycles.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      starve_cnt     <= '0;
      force_bubble_q <= 1'b0;
    end else if (!empty && bus.wb_we) begin
      if (starve_cnt == SW'(STARVE_LIMIT - 1)) begin
        starve_cnt     <= '0;
        force_bubble_q <= 1'b1;
      end else begin
        starve_cnt     <= starve_cnt + SW'(1);
        force_bubble_q <= 1'b0;
      end
    end else begin
      starve_cnt     <= '0;
      force_bubble_q <= 1'b0;
    end
  end

  assign bus.force_bubble = force_bubble_q;

  no_wb_in_bubble: assert property (@(posedge clk) disable iff (rst)
    !(force_bubble_q && bus.wb_we))
    else $error("wb_we asserted while force_bubble was high");

endmodule
